// File: rtl/rx_target_if.sv
// Target-side sdio pins plus the register access port of rx_target.
// The slave modport is the target's view; master is the host/register-file side.
interface rx_target_if;
    logic        sdi;
    logic        sdo;
    logic        sdo_oe;
    logic        reg_wvalid;
    logic [3:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic [15:0] reg_rdata;

    modport master (
        output sdi, reg_rdata,
        input  sdo, sdo_oe, reg_wvalid, reg_addr, reg_wdata
    );

    modport slave (
        input  sdi, reg_rdata,
        output sdo, sdo_oe, reg_wvalid, reg_addr, reg_wdata
    );
endinterface

// File: rtl/rx_target.sv
// Remote end of the sdio link: decodes a 22-bit command frame, strobes a register
// write, then turns the bus around and returns scrambled samples plus a readback word.
module rx_target #(
    parameter int TX_ON     = 25,
    parameter int TX_OFFSET = 32,
    parameter int TX_BITS   = 208
) (
    input  logic         clock,
    input  logic         reset,
    rx_target_if.slave   bus,
    input  logic [191:0] sample_data,
    output logic         sample_latch,
    output logic         frame_err
);
    typedef enum logic [2:0] {IDLE, START2, CMD, TURN, TX} state_t;

    localparam logic [21:0] LFSR_SEED       = 22'h3FFFFF;
    localparam logic [7:0]  S_CMD_LAST      = 8'd21;
    localparam logic [7:0]  S_OE_LOAD       = 8'(TX_ON - 1);
    localparam logic [7:0]  S_TX_LOAD_FIRST = 8'(TX_OFFSET - 1);
    localparam logic [7:0]  S_TX_LAST       = 8'(TX_OFFSET + TX_BITS - 1);
    localparam logic [7:0]  SAMPLE_BITS     = 8'd192;

    state_t        state, state_next;
    logic [7:0]    slot;
    logic [18:0]   cmd_shift;
    logic [19:0]   cmd_word;
    logic [191:0]  shadow;
    logic [15:0]   readback;
    logic [21:0]   lfsr, lfsr_next;
    logic          lfsr_reseed;
    logic [7:0]    bit_idx;
    logic [2:0]    chan;
    logic [4:0]    chan_bit;
    logic [7:0]    sample_idx;
    logic          data_bit;
    logic          load_bit;
    logic          sdo_next, sdo_oe_next;

    assign cmd_word = {cmd_shift, bus.sdi};

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next   = state;
        sample_latch = 1'b0;
        frame_err    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!bus.sdi) begin
                    state_next   = START2;
                    sample_latch = 1'b1;
                end
            end
            START2: begin
                if (bus.sdi) begin
                    state_next = IDLE;
                    frame_err  = 1'b1;
                end else begin
                    state_next = CMD;
                end
            end
            CMD:  if (slot == S_CMD_LAST)      state_next = TURN;
            TURN: if (slot == S_TX_LOAD_FIRST) state_next = TX;
            TX:   if (slot == S_TX_LAST)       state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (reset) begin
            sample_latch = 1'b0;
            frame_err    = 1'b0;
        end
    end

    // sdo is loaded one slot ahead, so bit n is computed at s=TX_OFFSET-1+n
    // and scrambled with the LFSR value that will be current when it is on the wire.
    always_comb begin
        lfsr_reseed = (state == TURN) && (slot == S_TX_LOAD_FIRST) && (bus.reg_addr == 4'h4);
        lfsr_next   = lfsr_reseed ? LFSR_SEED : {lfsr[20:0], lfsr[21] ^ lfsr[20]};

        bit_idx    = slot - S_TX_LOAD_FIRST;
        chan       = ~bit_idx[2:0];
        chan_bit   = 5'd23 - bit_idx[7:3];
        sample_idx = {1'b0, chan, 4'b0} + {2'b0, chan, 3'b0} + {3'b0, chan_bit};

        if (bit_idx < SAMPLE_BITS) begin
            data_bit = shadow[sample_idx] ^ lfsr_next[21];
        end else begin
            data_bit = readback[~bit_idx[3:0]];
        end

        load_bit    = ((state == TURN) && (slot == S_TX_LOAD_FIRST)) ||
                      ((state == TX) && (slot != S_TX_LAST));
        sdo_next    = load_bit ? data_bit : 1'b1;
        sdo_oe_next = ((state == TURN) && (slot >= S_OE_LOAD)) ||
                      ((state == TX) && (slot != S_TX_LAST));
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            slot           <= 8'd0;
            lfsr           <= LFSR_SEED;
            bus.sdo        <= 1'b1;
            bus.sdo_oe     <= 1'b0;
            bus.reg_wvalid <= 1'b0;
            bus.reg_addr   <= 4'hF;
            bus.reg_wdata  <= 16'h0000;
        end else begin
            state          <= state_next;
            slot           <= (state_next == IDLE) ? 8'd0 : slot + 8'd1;
            lfsr           <= lfsr_next;
            bus.sdo        <= sdo_next;
            bus.sdo_oe     <= sdo_oe_next;
            bus.reg_wvalid <= 1'b0;
            if ((state == CMD) && (slot == S_CMD_LAST)) begin
                bus.reg_addr   <= cmd_word[19:16];
                bus.reg_wdata  <= cmd_word[15:0];
                bus.reg_wvalid <= ~cmd_word[19];
            end
        end
    end

    // NOTE: datapath registers carry no reset; each is only consumed after a qualified load in the current frame.
    always_ff @(posedge clock) begin
        if (sample_latch) begin
            shadow <= sample_data;
        end
        if (state == CMD) begin
            cmd_shift <= {cmd_shift[17:0], bus.sdi};
        end
        if ((state == TURN) && (slot == S_TX_LOAD_FIRST)) begin
            readback <= bus.reg_rdata;
        end
    end
endmodule
